// File: rtl/i2s_rx.sv
// I2S slave receiver: resynchronises sclk/lrclk/sdata into clk and delivers
// one left/right pair per frame with a one-cycle valid strobe and a lock flag.
module i2s_rx #(
  parameter int AUDIO_DW = 16,
  parameter int TIMEOUT  = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sclk,
  input  logic                lrclk,
  input  logic                sdata,
  output logic [AUDIO_DW-1:0] left_chan,
  output logic [AUDIO_DW-1:0] right_chan,
  output logic                sample_valid,
  output logic                locked
);

  localparam int            TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    CNT_MAX = 8'(AUDIO_DW);

  typedef enum logic {HUNT, RUN} state_t;

  state_t              state;
  logic                sclk_s1, sclk_s2, sclk_s3;
  logic                lrclk_s1, lrclk_s2;
  logic                sdata_s1, sdata_s2;
  logic [AUDIO_DW-1:0] shreg;
  logic [AUDIO_DW-1:0] left_hold;
  logic [AUDIO_DW-1:0] word;
  logic [7:0]          bit_cnt;
  logic                lr_prev;
  logic                primed;
  logic                have_left;
  logic [TW-1:0]       to_cnt;
  logic                rise;
  logic                lr_change;

  assign rise      = sclk_s2 & ~sclk_s3;
  assign lr_change = lrclk_s2 != lr_prev;

  // Shift register with the current bit merged in; bits past AUDIO_DW fall off.
  always_comb begin
    word = shreg;
    for (int i = 0; i < AUDIO_DW; i++)
      if (bit_cnt == 8'(AUDIO_DW - 1 - i)) word[i] = sdata_s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s1      <= 1'b0;
      sclk_s2      <= 1'b0;
      sclk_s3      <= 1'b0;
      lrclk_s1     <= 1'b0;
      lrclk_s2     <= 1'b0;
      sdata_s1     <= 1'b0;
      sdata_s2     <= 1'b0;
      state        <= HUNT;
      shreg        <= '0;
      left_hold    <= '0;
      bit_cnt      <= '0;
      lr_prev      <= 1'b0;
      primed       <= 1'b0;
      have_left    <= 1'b0;
      to_cnt       <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      locked       <= 1'b0;
    end else begin
      sclk_s1      <= sclk;
      sclk_s2      <= sclk_s1;
      sclk_s3      <= sclk_s2;
      lrclk_s1     <= lrclk;
      lrclk_s2     <= lrclk_s1;
      sdata_s1     <= sdata;
      sdata_s2     <= sdata_s1;
      sample_valid <= 1'b0;

      if (rise) begin
        to_cnt <= '0;
        case (state)
          HUNT: begin
            if (!primed) begin
              lr_prev <= lrclk_s2;
              primed  <= 1'b1;
            end else if (lr_change) begin
              state     <= RUN;
              lr_prev   <= lrclk_s2;
              shreg     <= '0;
              bit_cnt   <= '0;
              have_left <= 1'b0;
            end
          end
          RUN: begin
            if (lr_change) begin
              // The bit on this rise is the LSB of the word that just ended.
              shreg   <= '0;
              bit_cnt <= '0;
              lr_prev <= lrclk_s2;
              if (!lr_prev) begin
                left_hold <= word;
                have_left <= 1'b1;
              end else if (have_left) begin
                left_chan    <= left_hold;
                right_chan   <= word;
                sample_valid <= 1'b1;
                locked       <= 1'b1;
                have_left    <= 1'b0;
              end
            end else begin
              shreg <= word;
              if (bit_cnt != CNT_MAX) bit_cnt <= bit_cnt + 8'd1;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (to_cnt != TO_MAX) begin
        to_cnt <= to_cnt + TW'(1);
        if (to_cnt == TO_LAST) begin
          state     <= HUNT;
          locked    <= 1'b0;
          primed    <= 1'b0;
          have_left <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/i2s_rx.md
# i2s_rx

I2S slave receiver: recovers stereo PCM samples from an external serial audio stream (sclk, lrclk, sdata) into the system `clk` domain. It is the receive counterpart of the system-side I2S transmitter and uses the same framing: MSB first, lrclk low = left, lrclk high = right, and a one-bit delay after each lrclk transition. It sits between an external audio source (ADC, HDMI audio extractor, loopback of our own transmitter) and the audio mixer, delivering one parallel left/right pair per frame with a valid strobe.

## Interface
- `AUDIO_DW`, 16: output sample width in bits (2..64).
- `TIMEOUT`, 1024: number of `clk` cycles without an sclk rising edge that forces loss of lock.

- `clk` in 1: system clock. All logic runs on its rising edge.
- `reset` in 1: synchronous, active-high.
- `sclk` in 1: external bit clock, asynchronous to `clk`.
- `lrclk` in 1: external word select, asynchronous to `clk`. 0 = left, 1 = right.
- `sdata` in 1: external serial data, asynchronous to `clk`. It changes after the sclk falling edge.
- `left_chan` out AUDIO_DW: last complete left sample.
- `right_chan` out AUDIO_DW: last complete right sample.
- `sample_valid` out 1: one-cycle pulse when `left_chan`/`right_chan` update.
- `locked` out 1: high once a full pair has been received; low after reset or timeout.

## Operation
- **Synchronisation**
  - `sclk`, `lrclk` and `sdata` each pass through a 2-FF synchroniser (stages s1, s2).
  - `sclk` has an additional stage s3.
  - `rise = sclk_s2 & ~sclk_s3`.
  - On `rise`, the bit and word select used are `sdata_s2` and `lrclk_s2`.
- **Input constraint:** sclk high and low phases must each be at least 2 `clk` cycles.
- **Internal state**
  - `shreg[AUDIO_DW-1:0]`
  - `bit_cnt` (8 bit, saturating at AUDIO_DW)
  - `lr_prev`
  - `primed`
  - `left_hold[AUDIO_DW-1:0]`
  - `have_left`
  - `to_cnt`
  - state ∈ {HUNT, RUN}
- **Bit capture (every `rise` in RUN):**
  - If `bit_cnt < AUDIO_DW`, write the bit to `shreg[AUDIO_DW-1-bit_cnt]`.
  - Then `bit_cnt` increments, saturating at AUDIO_DW.
  - Words longer than AUDIO_DW are truncated (LSBs dropped).
  - Words shorter than AUDIO_DW are left-aligned and zero-padded.
- **Word end:** a `rise` with `lrclk_s2 != lr_prev`.
  - The bit captured on that same rise is the LSB of the word just ending.
  - The completed word is `shreg` including that bit.
  - After the word is taken, `shreg` clears to 0 and `bit_cnt` clears to 0.
  - `lr_prev` ← `lrclk_s2`.
- **Completed word with `lr_prev` = 0 (left):** `left_hold` ← word, `have_left` ← 1.
- **Completed word with `lr_prev` = 1 (right):**
  - If `have_left` = 1: `left_chan` ← `left_hold`, `right_chan` ← word, `sample_valid` pulses, `locked` ← 1, `have_left` ← 0.
  - If `have_left` = 0: the word is discarded.
- **HUNT** (entered on reset and on timeout):
  - A `rise` with `primed` = 0 records `lr_prev` ← `lrclk_s2` and sets `primed`.
  - A `rise` with `primed` = 1 and a lrclk change moves to RUN with `shreg` = 0, `bit_cnt` = 0, `have_left` = 0. That rise's bit is discarded.
  - The partial word in progress at lock-on is never emitted.
- **Timeout**
  - `to_cnt` clears on every `rise` and otherwise increments, saturating.
  - When `to_cnt` reaches TIMEOUT: state ← HUNT, `locked` ← 0, `primed` ← 0, `have_left` ← 0.
  - `left_chan` and `right_chan` hold their values.
- **Reset:**
  - Outputs: `left_chan` = 0, `right_chan` = 0, `sample_valid` = 0, `locked` = 0.
  - Internal: state HUNT, all other registers 0.
  - Reset mid-word discards everything in flight.

## Timing
- **Latency:** if s1 captures sclk high at `clk` edge E0, the resulting `rise` is acted on at edge E2.
  - On the LSB of a right word, `left_chan`, `right_chan` and `sample_valid` are valid after E2.
- **Strobe:** `sample_valid` is high for exactly one cycle, at most once per lrclk period.
- **Output registers:** `left_chan` and `right_chan` change only in the cycle `sample_valid` is high.
- **Lock:** `locked` rises with the first `sample_valid` and falls in the cycle `to_cnt` reaches TIMEOUT.
- **Reset vs. rise:** a `rise` coinciding with `reset` is ignored.
- **Simultaneous timeout and rise:** the rise wins and `to_cnt` clears.

## Test plan
- **Reset:** hold `reset` 5 cycles with toggling inputs → all outputs 0 and `locked` = 0 through reset and until the first complete pair.
- **Nominal stream:** loop back the system I2S transmitter (AUDIO_DW = 16, ce every 2 clk) sending L = 16'hA55A, R = 16'h1234.
  - `locked` rises with the first `sample_valid`.
  - Every following frame gives one pulse with `left_chan` = 16'hA55A and `right_chan` = 16'h1234.
- **Word length mismatch** (AUDIO_DW = 16):
  - 24-bit frames with L = 24'h123456, R = 24'hFEDCBA → 16'h1234 / 16'hFEDC.
  - 8-bit frames with L = 8'hC3, R = 8'h5A → 16'hC300 / 16'h5A00.
- **Mid-frame start:** release reset halfway through a right word of L = 16'h0F0F, R = 16'hF0F0.
  - No pulse for the partial right word or the first left-less right word.
  - The first pulse carries 16'h0F0F / 16'hF0F0.
- **Timeout:** stop sclk after lock with TIMEOUT = 64.
  - `locked` falls exactly 64 cycles after the last `rise`; outputs hold.
  - After sclk resumes, the next pulse comes only after a new full left+right pair.
- **Reset mid-word:** assert `reset` for 1 cycle while receiving the left word of 16'h8001 / 16'h7FFE.
  - Outputs read 0 on the next cycle.
  - Re-lock follows the HUNT rules; the first pulse carries 16'h8001 / 16'h7FFE.
